// File: rtl/envelope_shaper.sv
`default_nettype none
// ============================================================================
// Module   : envelope_shaper
// Brief    : ADSR-style envelope generator that scales an oscillator sample.
// Revision : 1.0 - initial release
// ============================================================================

module envelope_shaper #(
  parameter int ATTACK_DIV  = 64,
  parameter int DECAY_DIV   = 128,
  parameter int SUSTAIN_LVL = 180,
  parameter int RELEASE_DIV = 256
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       gate,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic [7:0] env_level,
  output logic [2:0] env_state,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [15:0] c_ATTACK_LAST  = 16'(ATTACK_DIV - 1);
  localparam logic [15:0] c_DECAY_LAST   = 16'(DECAY_DIV - 1);
  localparam logic [15:0] c_RELEASE_LAST = 16'(RELEASE_DIV - 1);
  localparam logic [7:0]  c_SUSTAIN      = 8'(SUSTAIN_LVL);

  state_t      state_q, state_d;
  logic        gate_q;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  sample_q;
  logic        busy_q;
  logic [15:0] w_div_last;
  logic        w_tick;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    w_div_last = 16'd0;

    case (state_q)
      S_ATTACK:  w_div_last = c_ATTACK_LAST;
      S_DECAY:   w_div_last = c_DECAY_LAST;
      S_RELEASE: w_div_last = c_RELEASE_LAST;
      default:   w_div_last = 16'd0;
    endcase

    w_tick = (pre_q == w_div_last);
    pre_d  = w_tick ? 16'd0 : pre_q + 16'd1;

    // A dropped (or re-raised) gate always wins over stepping and other moves.
    case (state_q)
      S_IDLE: begin
        if (gate_q) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate_q) begin
          state_d = S_RELEASE;
        end else if (level_q == 8'd255) begin
          state_d = S_DECAY;
        end else if (w_tick) begin
          level_d = level_q + 8'd1;
          if (level_q == 8'd254) state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (!gate_q) begin
          state_d = S_RELEASE;
        end else if (level_q <= c_SUSTAIN) begin
          state_d = S_SUSTAIN;
        end else if (w_tick) begin
          level_d = level_q - 8'd1;
        end
      end
      S_SUSTAIN: begin
        if (!gate_q) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (gate_q) begin
          state_d = S_ATTACK;
        end else if (level_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (w_tick) begin
          level_d = level_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = 8'd0;
      end
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_SUSTAIN)) begin
      pre_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state_q  <= S_IDLE;
      gate_q   <= 1'b0;
      pre_q    <= 16'd0;
      level_q  <= 8'd0;
      sample_q <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate;
      pre_q    <= pre_d;
      level_q  <= level_d;
      // Uses the level from before this edge's update: one-cycle latency.
      sample_q <= 8'(({8'd0, sample_in} * {8'd0, level_q}) >> 8);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign sample_out = sample_q;
  assign env_level  = level_q;
  assign env_state  = state_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_envelope_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_shaper
// Brief    : Self-checking bench for envelope_shaper with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_envelope_shaper;

  localparam int AD = 4;
  localparam int DD = 2;
  localparam int SL = 200;
  localparam int RD = 1;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic       gate = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic [7:0] sample_out;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;

  envelope_shaper #(
    .ATTACK_DIV (AD),
    .DECAY_DIV  (DD),
    .SUSTAIN_LVL(SL),
    .RELEASE_DIV(RD)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .gate      (gate),
    .sample_in (sample_in),
    .sample_out(sample_out),
    .env_level (env_level),
    .env_state (env_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: phase numbers follow the published state encoding; m_cnt is the
  // number of cycles already spent in the current step interval.
  int m_gate, m_phase, m_level, m_cnt, m_sout;

  typedef struct {
    logic [7:0] sin;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [6];

  function automatic int step_period(input int ph);
    case (ph)
      1:       return AD;
      2:       return DD;
      4:       return RD;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_gate = 0; m_phase = 0; m_level = 0; m_cnt = 0; m_sout = 0;
  endtask

  task automatic model_edge(input int g, input int sin);
    int  nph, nlev, ncnt;
    bit  due;
    nph  = m_phase;
    nlev = m_level;
    due  = (m_cnt + 1 >= step_period(m_phase));
    ncnt = due ? 0 : m_cnt + 1;
    m_sout = (sin * m_level) / 256;
    case (m_phase)
      0: if (m_gate != 0) nph = 1;
      1: begin
        if (m_gate == 0) nph = 4;
        else if (m_level == 255) nph = 2;
        else if (due) begin
          nlev = m_level + 1;
          if (nlev == 255) nph = 2;
        end
      end
      2: begin
        if (m_gate == 0) nph = 4;
        else if (m_level <= SL) nph = 3;
        else if (due) nlev = m_level - 1;
      end
      3: if (m_gate == 0) nph = 4;
      default: begin
        if (m_gate != 0) nph = 1;
        else if (m_level == 0) nph = 0;
        else if (due) nlev = m_level - 1;
      end
    endcase
    if (nph != m_phase || m_phase == 0 || m_phase == 3) ncnt = 0;
    m_phase = nph;
    m_level = nlev;
    m_cnt   = ncnt;
    m_gate  = g;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_level",  int'(env_level),  m_level);
    check("model_state",  int'(env_state),  m_phase);
    check("model_busy",   int'(busy),       (m_phase != 0) ? 1 : 0);
    check("model_sample", int'(sample_out), m_sout);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(int'(gate), int'(sample_in));
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous pulse placed between edges; outputs must clear at once.
  task automatic pulse_reset();
    #2 nRst = 1'b1;
    #1;
    check("rst_level",  int'(env_level),  0);
    check("rst_state",  int'(env_state),  0);
    check("rst_busy",   int'(busy),       0);
    check("rst_sample", int'(sample_out), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    nRst = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{8'd255, 8'd199};
    tbl[1] = '{8'd128, 8'd100};
    tbl[2] = '{8'd0,   8'd0};
    tbl[3] = '{8'd1,   8'd0};
    tbl[4] = '{8'd77,  8'd60};
    tbl[5] = '{8'd200, 8'd156};

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_level",  int'(env_level),  0);
    check("reset_state",  int'(env_state),  0);
    check("reset_busy",   int'(busy),       0);
    check("reset_sample", int'(sample_out), 0);
    nRst = 1'b0;
    cycle();

    // Attack timing and peak
    sample_in = 8'd255;
    gate = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!busy && n < 10);
    check("busy_latency", n, 2);
    n = 0;
    while (env_state != 3'd2 && n < 2000) begin cycle(); n++; end
    check("attack_cycles", n, 1020);
    check("peak_level", int'(env_level), 255);
    cycle();
    check("peak_sample", int'(sample_out), 254);

    // Decay to sustain
    n = 1;
    while (env_level != 8'd200 && n < 500) begin cycle(); n++; end
    check("decay_cycles", n, 110);
    cycle();
    check("sustain_state", int'(env_state), 3);
    repeat (20) cycle();
    check("sustain_hold", int'(env_level), 200);

    for (int i = 0; i < 6; i++) begin
      sample_in = tbl[i].sin;
      cycle();
      check("tbl_sample", int'(sample_out), int'(tbl[i].exp));
    end

    // Reset in sustain with gate held: restart from zero
    pulse_reset();
    cycle();
    check("restart_idle", int'(env_state), 0);
    cycle();
    check("restart_attack", int'(env_state), 1);
    check("restart_level", int'(env_level), 0);

    // Gate drop at level 100, fast release
    n = 0;
    while (env_level != 8'd100 && n < 1000) begin cycle(); n++; end
    check("reach_100", int'(env_level), 100);
    gate = 1'b0;
    sample_in = 8'd255;
    cycle();
    cycle();
    check("release_state", int'(env_state), 4);
    check("release_level", int'(env_level), 100);
    n = 0;
    while (env_level != 8'd0 && n < 500) begin cycle(); n++; end
    check("release_cycles", n, 100);
    cycle();
    check("idle_state", int'(env_state), 0);
    check("idle_busy", int'(busy), 0);
    cycle();
    check("zero_sample", int'(sample_out), 0);

    // Mid-scale product, then retrigger during release
    gate = 1'b1;
    n = 0;
    while (env_level != 8'd128 && n < 1000) begin cycle(); n++; end
    sample_in = 8'd128;
    cycle();
    check("mid_sample", int'(sample_out), 64);
    gate = 1'b0;
    cycle();
    cycle();
    check("rel2_state", int'(env_state), 4);
    n = 0;
    while (env_level != 8'd51 && n < 500) begin cycle(); n++; end
    gate = 1'b1;
    cycle();
    cycle();
    check("retrig_state", int'(env_state), 1);
    check("retrig_level", int'(env_level), 50);
    repeat (4) cycle();
    check("retrig_ramp", int'(env_level), 51);

    // Randomised gate segments with occasional resets
    for (int s = 0; s < 40; s++) begin
      int len;
      gate = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 300);
      if ($urandom_range(0, 9) == 0) pulse_reset();
      for (int c = 0; c < len; c++) begin
        sample_in = 8'($urandom);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
